dtpu_infifo: RTL and testbench

Parametrised input-data FIFO between the PS-side AXI-stream DMA and the dtpu_core input FIFO port (infifo_is_empty / infifo_dout / infifo_read). It buffers DEPTH words of DATA_WIDTH bits and carries a per-word last marker. It reports level and almost-full/almost-empty watermarks, supports a synchronous flush, and latches read-underflow errors. The read side gives the one-cycle-latency, zero-when-idle data behaviour dtpu_core expects.

---
 rtl/dtpu_infifo.sv | 105 ++++++++++
 tb/tb_dtpu_infifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dtpu_infifo.sv
// Input-data FIFO that sits between the AXI-stream DMA and the dtpu_core input port.
// It stores a last marker with each word and gives a registered read that returns zero when idle.
module dtpu_infifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    input  logic                         infifo_read,
    output logic                         infifo_is_empty,
    output logic [DATA_WIDTH-1:0]        infifo_dout,
    output logic                         infifo_last,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         underflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic [LW-1:0]         level_next;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  last_reg;
    logic                  err_reg;
    logic                  wr_en;
    logic                  rd_en;
    logic                  empty;

    assign empty         = (level_reg == '0);
    assign full          = (level_reg == LW'(DEPTH));
    assign s_axis_tready = !full && !flush;
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    // flush outranks reads, so a read in the flush cycle neither pops nor errors
    assign rd_en         = infifo_read && !empty && !flush;

    always_comb begin
        level_next = level_reg;
        if (wr_en && !rd_en) begin
            level_next = level_reg + LW'(1);
        end else if (rd_en && !wr_en) begin
            level_next = level_reg - LW'(1);
        end
    end

    // Storage carries no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
            last_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
            last_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg             <= rd_ptr_reg + PW'(1);
                {last_reg, dout_reg}   <= mem[rd_ptr_reg];
            end else begin
                last_reg <= 1'b0;
                dout_reg <= '0;
            end
            level_reg <= level_next;
            if (infifo_read && empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign infifo_is_empty = empty;
    assign infifo_dout     = dout_reg;
    assign infifo_last     = last_reg;
    assign level           = level_reg;
    assign almost_full     = (level_reg >= LW'(AF_THRESH));
    assign almost_empty    = (level_reg <= LW'(AE_THRESH));
    assign underflow_err   = err_reg;

endmodule

// File: tb/tb_dtpu_infifo.sv
// Bench for dtpu_infifo: a queue-based reference checked every cycle, plus directed
// literal expectations covering fill/drain, watermarks, full/empty corners, wrap, flush and reset.
module tb_dtpu_infifo;
    localparam int DW    = 64;
    localparam int DEPTH = 16;

    logic          clk;
    logic          aresetn;
    logic          flush;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          infifo_read;
    logic          infifo_is_empty;
    logic [DW-1:0] infifo_dout;
    logic          infifo_last;
    logic [4:0]    level;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic          underflow_err;

    int total = 0;
    int bad   = 0;

    dtpu_infifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(DEPTH-2), .AE_THRESH(2)) dut (
        .clk(clk), .aresetn(aresetn), .flush(flush),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .infifo_read(infifo_read), .infifo_is_empty(infifo_is_empty),
        .infifo_dout(infifo_dout), .infifo_last(infifo_last),
        .level(level), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .underflow_err(underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of {last,data} words; outputs follow from its size.
    logic [DW:0]   m_q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_last = 1'b0;
    logic          m_err  = 1'b0;

    initial begin
        logic [DW:0] e;
        logic        do_rd;
        logic        do_wr;
        forever begin
            @(posedge clk or negedge aresetn);
            if (!aresetn) begin
                m_q.delete();
                m_dout = '0;
                m_last = 1'b0;
                m_err  = 1'b0;
            end else if (flush) begin
                m_q.delete();
                m_dout = '0;
                m_last = 1'b0;
                m_err  = 1'b0;
                $display("flush");
            end else begin
                do_rd = infifo_read && (m_q.size() > 0);
                do_wr = s_axis_tvalid && (m_q.size() < DEPTH);
                if (infifo_read && m_q.size() == 0) begin
                    m_err = 1'b1;
                    $display("rd underflow");
                end
                if (do_rd) begin
                    e      = m_q.pop_front();
                    m_last = e[DW];
                    m_dout = e[DW-1:0];
                    $display("rd data=%h last=%0b", m_dout, m_last);
                end else begin
                    m_dout = '0;
                    m_last = 1'b0;
                end
                if (do_wr) begin
                    m_q.push_back({s_axis_tlast, s_axis_tdata});
                    $display("wr data=%h last=%0b", s_axis_tdata, s_axis_tlast);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_level",   64'(level),          64'(m_q.size()));
            chk("m_empty",   64'(infifo_is_empty), 64'(m_q.size() == 0));
            chk("m_full",    64'(full),           64'(m_q.size() == DEPTH));
            chk("m_af",      64'(almost_full),    64'(m_q.size() >= DEPTH-2));
            chk("m_ae",      64'(almost_empty),   64'(m_q.size() <= 2));
            chk("m_tready",  64'(s_axis_tready),  64'((m_q.size() < DEPTH) && !flush));
            chk("m_dout",    infifo_dout,         m_dout);
            chk("m_last",    64'(infifo_last),    64'(m_last));
            chk("m_err",     64'(underflow_err),  64'(m_err));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {8{b}};
    endfunction

    initial begin
        aresetn       = 1'b0;
        flush         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        infifo_read   = 1'b0;
        cyc();
        cyc();
        aresetn = 1'b1;
        cyc();
        chk("rst_empty",  64'(infifo_is_empty), 64'd1);
        chk("rst_level",  64'(level),           64'd0);
        chk("rst_tready", 64'(s_axis_tready),   64'd1);
        chk("rst_dout",   infifo_dout,          64'd0);
        chk("rst_err",    64'(underflow_err),   64'd0);

        // Fill with 0x0101.. .. 0x1010.., checking watermarks on the way up
        for (int k = 1; k <= DEPTH; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pat(k);
            s_axis_tlast  = (k == DEPTH);
            cyc();
            if (k == 2)  chk("ae_at2",  64'(almost_empty), 64'd1);
            if (k == 3)  chk("ae_at3",  64'(almost_empty), 64'd0);
            if (k == 13) chk("af_at13", 64'(almost_full),  64'd0);
            if (k == 14) chk("af_at14", 64'(almost_full),  64'd1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("fill_full",   64'(full),          64'd1);
        chk("fill_tready", 64'(s_axis_tready), 64'd0);
        chk("fill_level",  64'(level),         64'd16);

        infifo_read = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            cyc();
            chk("drain_dout", infifo_dout,       pat(k));
            chk("drain_last", 64'(infifo_last),  64'(k == DEPTH));
        end
        infifo_read = 1'b0;
        chk("drain_empty", 64'(infifo_is_empty), 64'd1);
        cyc();
        chk("idle_dout", infifo_dout, 64'd0);

        // Full plus simultaneous write and read
        for (int k = 1; k <= DEPTH; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 64'h100 + 64'(k);
            cyc();
        end
        s_axis_tdata = 64'hBAD0_BAD0;
        infifo_read  = 1'b1;
        cyc();
        s_axis_tvalid = 1'b0;
        chk("fullrw_level", 64'(level),  64'd15);
        chk("fullrw_dout",  infifo_dout, 64'h101);
        for (int k = 2; k <= DEPTH; k++) begin
            cyc();
            chk("fullrw_drain", infifo_dout, 64'h100 + 64'(k));
        end
        infifo_read = 1'b0;
        cyc();

        // Empty plus simultaneous write and read
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hABCD;
        infifo_read   = 1'b1;
        cyc();
        s_axis_tvalid = 1'b0;
        chk("emptyrw_err",   64'(underflow_err), 64'd1);
        chk("emptyrw_dout",  infifo_dout,        64'd0);
        chk("emptyrw_level", 64'(level),         64'd1);
        cyc();
        infifo_read = 1'b0;
        chk("emptyrw_next", infifo_dout, 64'hABCD);

        // Flush at level 7 with the error flag set; the write in the flush cycle is dropped
        for (int k = 0; k < 7; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 64'h700 + 64'(k);
            cyc();
        end
        chk("pre_flush_level", 64'(level),         64'd7);
        chk("pre_flush_err",   64'(underflow_err), 64'd1);
        flush        = 1'b1;
        s_axis_tdata = 64'hDEAD;
        cyc();
        flush         = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("flush_level", 64'(level),           64'd0);
        chk("flush_empty", 64'(infifo_is_empty), 64'd1);
        chk("flush_err",   64'(underflow_err),   64'd0);
        cyc();
        chk("flush_nowr", 64'(level), 64'd0);

        // Interleaved single writes and reads wrap both pointers
        for (int k = 0; k < 40; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 64'hC000 + 64'(k);
            cyc();
            s_axis_tvalid = 1'b0;
            chk("wrap_lvl1", 64'(level), 64'd1);
            infifo_read = 1'b1;
            cyc();
            infifo_read = 1'b0;
            chk("wrap_dout", infifo_dout, 64'hC000 + 64'(k));
            chk("wrap_lvl0", 64'(level),  64'd0);
        end

        // Asynchronous reset mid-cycle with 5 words stored
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 64'hE00 + 64'(k);
            cyc();
        end
        s_axis_tvalid = 1'b0;
        chk("pre_arst_level", 64'(level), 64'd5);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_level", 64'(level),           64'd0);
        chk("arst_empty", 64'(infifo_is_empty), 64'd1);
        cyc();
        aresetn = 1'b1;
        cyc();
        cyc();
        chk("post_arst_level", 64'(level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
